// File: rtl/room_temp_model_if.sv
// Command/observation bundle between the air-conditioning controller and the thermal plant.
interface room_temp_model_if;
  logic       heating;
  logic       cooling;
  logic [4:0] temperature;
  logic       changed;
  logic       fault;

  modport master (output heating, output cooling,
                  input  temperature, input changed, input fault);
  modport slave  (input  heating, input cooling,
                  output temperature, output changed, output fault);
endinterface

// File: rtl/room_temp_model.sv
// Prescaled thermal plant: heats, cools or drifts toward ambient one degree per step,
// freezing with a sticky fault if heating and cooling are ever commanded together.
module room_temp_model #(
  parameter int unsigned RATE_DIV  = 4,
  parameter int unsigned DRIFT_DIV = 8,
  parameter int unsigned AMBIENT   = 15,
  parameter int unsigned INIT_TEMP = 20
) (
  input  logic              clk,
  input  logic              rst,
  room_temp_model_if.slave  bus
);

  localparam int unsigned TW = 5;
  localparam int unsigned CW = 16;
  localparam logic [TW-1:0] AMB_T   = TW'(AMBIENT);
  localparam logic [TW-1:0] INIT_T  = TW'(INIT_TEMP);
  localparam logic [TW-1:0] MAX_T   = TW'(31);
  localparam logic [CW-1:0] RATE_M1  = CW'(RATE_DIV - 1);
  localparam logic [CW-1:0] DRIFT_M1 = CW'(DRIFT_DIV - 1);

  typedef enum logic [1:0] {
    MODE_IDLE     = 2'd0,
    MODE_HEAT     = 2'd1,
    MODE_COOL     = 2'd2,
    MODE_CONFLICT = 2'd3
  } mode_e;

  mode_e         r_mode_q;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_temperature;
  logic          r_changed;
  logic          r_fault;

  mode_e         w_mode;
  logic [CW-1:0] w_div_m1;
  logic [TW-1:0] w_step_temp;

  // Decode the current command pair and the value a step would produce in this mode.
  always_comb begin
    w_mode      = MODE_IDLE;
    w_div_m1    = DRIFT_M1;
    w_step_temp = r_temperature;
    unique case ({bus.heating, bus.cooling})
      2'b10:   w_mode = MODE_HEAT;
      2'b01:   w_mode = MODE_COOL;
      2'b11:   w_mode = MODE_CONFLICT;
      default: w_mode = MODE_IDLE;
    endcase
    unique case (w_mode)
      MODE_HEAT: begin
        w_div_m1    = RATE_M1;
        w_step_temp = (r_temperature == MAX_T) ? r_temperature : r_temperature + TW'(1);
      end
      MODE_COOL: begin
        w_div_m1    = RATE_M1;
        w_step_temp = (r_temperature == '0) ? r_temperature : r_temperature - TW'(1);
      end
      MODE_IDLE: begin
        w_div_m1 = DRIFT_M1;
        if (r_temperature < AMB_T)      w_step_temp = r_temperature + TW'(1);
        else if (r_temperature > AMB_T) w_step_temp = r_temperature - TW'(1);
        else                            w_step_temp = r_temperature;
      end
      default: begin
        w_div_m1    = DRIFT_M1;
        w_step_temp = r_temperature;
      end
    endcase
  end

  // Prescaler, temperature and fault state; a mode change restarts the prescaler without stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_q      <= MODE_IDLE;
      r_cnt         <= '0;
      r_temperature <= INIT_T;
      r_changed     <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      if (r_fault) begin
        r_cnt <= r_cnt;
      end else if (w_mode == MODE_CONFLICT) begin
        r_fault <= 1'b1;
      end else if (w_mode != r_mode_q) begin
        r_mode_q <= w_mode;
        r_cnt    <= '0;
      end else if (r_cnt == w_div_m1) begin
        r_cnt         <= '0;
        r_temperature <= w_step_temp;
        r_changed     <= (w_step_temp != r_temperature);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign bus.temperature = r_temperature;
  assign bus.changed     = r_changed;
  assign bus.fault       = r_fault;

endmodule

// File: tb/tb_room_temp_model.sv
// Vector-table, directed and randomized checking of the thermal plant against a behavioural model.
module tb_room_temp_model;

  localparam int RATE  = 4;
  localparam int DRIFT = 8;
  localparam int AMB   = 15;
  localparam int INIT  = 20;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  room_temp_model_if bus ();
  room_temp_model_if bus2 ();

  room_temp_model #(.RATE_DIV(RATE), .DRIFT_DIV(DRIFT), .AMBIENT(AMB), .INIT_TEMP(INIT))
    dut (.clk(clk), .rst(rst), .bus(bus));

  room_temp_model #(.RATE_DIV(RATE), .DRIFT_DIV(DRIFT), .AMBIENT(AMB), .INIT_TEMP(10))
    dut_cold (.clk(clk), .rst(rst2), .bus(bus2));

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: a step is due every DIV edges of uninterrupted mode, counted from the
  // edge on which that mode was first seen.
  int m_temp, m_run, m_prev;
  bit m_chg, m_fault;

  function automatic void model_edge(input bit r, input bit h, input bit c);
    int mode, div, nt;
    m_chg = 1'b0;
    if (r) begin
      m_temp = INIT; m_fault = 1'b0; m_prev = 0; m_run = 1;
      return;
    end
    if (m_fault) return;
    if (h && c) begin
      m_fault = 1'b1;
      return;
    end
    mode = h ? 1 : (c ? 2 : 0);
    if (mode != m_prev) begin
      m_prev = mode; m_run = 1;
      return;
    end
    m_run++;
    div = (mode == 0) ? DRIFT : RATE;
    if ((m_run - 1) % div == 0) begin
      if (mode == 1)      nt = (m_temp + 1 > 31) ? 31 : m_temp + 1;
      else if (mode == 2) nt = (m_temp - 1 < 0) ? 0 : m_temp - 1;
      else if (m_temp < AMB) nt = m_temp + 1;
      else if (m_temp > AMB) nt = m_temp - 1;
      else nt = m_temp;
      m_chg  = (nt != m_temp);
      m_temp = nt;
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic cycle(input bit r, input bit h, input bit c);
    rst = r; bus.heating = h; bus.cooling = c;
    @(posedge clk);
    model_edge(r, h, c);
    #1;
  endtask

  typedef struct {
    bit r, h, c;
    int n;
    int t;
    bit chg, flt;
  } vec_t;

  vec_t vq[$];

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bus.heating = 1'b0; bus.cooling = 1'b0;
    bus2.heating = 1'b0; bus2.cooling = 1'b0;
    m_temp = INIT; m_fault = 0; m_prev = 0; m_run = 1; m_chg = 0;

    // {rst, heat, cool, edges, temperature, changed, fault} checked after the last edge
    vq.push_back('{1,0,0,  2, 20,0,0});
    vq.push_back('{0,1,0,  5, 21,1,0});
    vq.push_back('{0,1,0,  4, 22,1,0});
    vq.push_back('{0,1,0, 36, 31,1,0});
    vq.push_back('{0,1,0,  4, 31,0,0});
    vq.push_back('{0,0,1,  1, 31,0,0});
    vq.push_back('{0,0,1,  4, 30,1,0});
    vq.push_back('{0,0,0,  1, 30,0,0});
    vq.push_back('{0,0,0,  8, 29,1,0});
    vq.push_back('{0,1,1,  1, 29,0,1});
    vq.push_back('{0,1,0, 20, 29,0,1});
    vq.push_back('{1,1,0,  1, 20,0,0});
    vq.push_back('{0,0,1, 13, 17,1,0});
    vq.push_back('{0,0,1, 68,  0,1,0});
    vq.push_back('{0,0,1,  8,  0,0,0});
    vq.push_back('{1,0,0,  1, 20,0,0});
    vq.push_back('{0,1,0, 21, 25,1,0});
    vq.push_back('{0,1,0,  2, 25,0,0});
    vq.push_back('{1,0,0,  2, 20,0,0});
    vq.push_back('{0,0,0,  7, 20,0,0});
    vq.push_back('{0,0,0,  1, 19,1,0});
    vq.push_back('{1,0,0,  1, 20,0,0});
    vq.push_back('{0,1,0,  9, 22,1,0});
    vq.push_back('{0,1,1,  1, 22,0,1});
    vq.push_back('{0,1,0,100, 22,0,1});
    vq.push_back('{1,1,0,  1, 20,0,0});

    for (int i = 0; i < vq.size(); i++) begin
      for (int k = 0; k < vq[i].n; k++) cycle(vq[i].r, vq[i].h, vq[i].c);
      check($sformatf("vec%0d temperature", i), int'(bus.temperature), vq[i].t);
      check($sformatf("vec%0d changed", i), int'(bus.changed), int'(vq[i].chg));
      check($sformatf("vec%0d fault", i), int'(bus.fault), int'(vq[i].flt));
    end

    // Mode chatter: HEAT/COOL alternating every 3 cycles never completes a prescale period.
    cycle(1, 0, 0);
    for (int k = 0; k < 60; k++) begin
      cycle(0, ((k / 3) % 2) == 0, ((k / 3) % 2) == 1);
      if (bus.changed !== 1'b0 || bus.temperature !== 5'd20 || bus.fault !== 1'b0) begin
        check($sformatf("chatter%0d temperature", k), int'(bus.temperature), 20);
        check($sformatf("chatter%0d changed", k), int'(bus.changed), 0);
        check($sformatf("chatter%0d fault", k), int'(bus.fault), 0);
      end
    end
    check("chatter end temperature", int'(bus.temperature), 20);
    check("chatter end fault", int'(bus.fault), 0);

    // Idle drift upward from a cold start on the second instance.
    cycle(1, 0, 0);
    rst2 = 1'b0;
    for (int e = 1; e <= 48; e++) begin
      cycle(0, 0, 0);
      if (e % 8 == 0 && e <= 40)
        check($sformatf("cold edge%0d temperature", e), int'(bus2.temperature), 10 + e / 8);
    end
    check("cold hold temperature", int'(bus2.temperature), AMB);
    check("cold hold changed", int'(bus2.changed), 0);
    check("warm drift settled", int'(bus.temperature), AMB);

    // Randomized runs against the model.
    cycle(1, 0, 0);
    for (int k = 0; k < 3000; ) begin
      int len, sel;
      bit r, h, c;
      len = int'($urandom_range(1, 24));
      sel = int'($urandom_range(0, 199));
      r = (sel < 2);
      h = 0; c = 0;
      if (sel == 2) begin h = 1; c = 1; len = 1; end
      else if (sel < 90) h = 1;
      else if (sel < 170) c = 1;
      for (int j = 0; j < len; j++) begin
        cycle(r, h, c);
        check("rand temperature", int'(bus.temperature), m_temp);
        check("rand changed", int'(bus.changed), int'(m_chg));
        check("rand fault", int'(bus.fault), int'(m_fault));
        k++;
      end
      if (m_fault && $urandom_range(0, 3) == 0) begin
        cycle(1, 0, 0);
        check("rand reset temperature", int'(bus.temperature), m_temp);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/room_temp_model.md
# room_temp_model

Behavioural-synthesisable thermal plant that closes the loop around the air-conditioning controller. It consumes the controller's `heating`/`cooling` commands and produces the 5-bit room `temperature` the controller reads. Temperature rises while heating, falls while cooling, and drifts toward a fixed ambient when neither is active. Each step is paced by a prescaler, so closed-loop runs show realistic hysteresis and settling.

## Interface
- `RATE_DIV`, 4: clock cycles per 1-degree step while heating or cooling (range 2..65535)
- `DRIFT_DIV`, 8: clock cycles per 1-degree drift step toward ambient when idle (range 2..65535)
- `AMBIENT`, 15: ambient temperature, 0..31
- `INIT_TEMP`, 20: temperature loaded on reset, 0..31

- `clk` input 1: system clock; all state updates on its rising edge
- `rst` input 1: synchronous, active-high reset
- `heating` input 1: heater command from the controller
- `cooling` input 1: cooler command from the controller
- `temperature` output 5: current room temperature, unsigned degrees, registered
- `changed` output 1: one-cycle pulse, high in the cycle `temperature` holds a newly stepped value
- `fault` output 1: sticky flag, set when `heating` and `cooling` are both high

## Operation
- Input mode, evaluated combinationally each cycle:
  - HEAT: `heating`=1, `cooling`=0
  - COOL: `heating`=0, `cooling`=1
  - IDLE: both 0
  - CONFLICT: both 1
- State registers:
  - `mode_q` (last sampled mode)
  - 16-bit prescaler `cnt`
  - `temperature`, `changed`, `fault`
- Reset values: `temperature`=INIT_TEMP, `changed`=0, `fault`=0, `mode_q`=IDLE, `cnt`=0. `rst` wins over every other event, including a step due in the same cycle.
- Frozen state: while `fault`=1, `temperature`, `cnt` and `mode_q` hold and `changed`=0. Only `rst` leaves this state.
- CONFLICT seen with `fault`=0: `fault`<=1 at that edge. No step occurs in that cycle.
- Otherwise, with DIV = RATE_DIV for HEAT/COOL and DRIFT_DIV for IDLE, at each edge:
  - Mode change (mode != `mode_q`): `cnt`<=0, `mode_q`<=mode, no step.
  - Terminal count (mode == `mode_q` and `cnt`==DIV-1): step fires and `cnt`<=0.
  - Otherwise: `cnt`<=`cnt`+1.
- Step rules:
  - HEAT: `temperature`+1, saturating at 31.
  - COOL: `temperature`-1, saturating at 0.
  - IDLE: move 1 toward AMBIENT; hold if equal.
- `changed`<=1 only when a step actually alters `temperature`. It is 0 when a step fires but the value is held (saturated, or already at AMBIENT). It is 0 in every other cycle.
- Arithmetic: 5-bit unsigned; saturation compares against 0/31 before adding, so the value never wraps.

## Timing
- Mode applied just before edge E0 and held thereafter:
  - first step lands at edge E0+DIV (DIV+1 edges including E0)
  - subsequent steps every DIV edges
- After reset release with inputs idle: `mode_q` is already IDLE, so the first drift step lands on the DRIFT_DIV-th edge.
- Mode held for fewer than DIV+1 edges produces no step. A HEAT→COOL→HEAT toggle restarts the prescaler each time.
- `temperature` and `changed` update on the same edge; there is no combinational path from inputs to outputs.
- `fault` rises on the edge that samples CONFLICT; that edge does not change `temperature`.

## Test plan
1. Reset: assert `rst` 2 cycles mid-run (at `temperature`=25, `cnt`≠0) → next cycle `temperature`=20, `changed`=0, `fault`=0. First idle drift step to 19 lands on the 8th edge after release.
2. Heating saturation: `heating`=1 from reset release → `temperature` 21 at edge 5, 22 at edge 9, …, 31 at edge 45 with `changed` pulsed 11 times. It holds 31 with no further `changed` pulses.
3. Cooling to floor: from 20, `cooling`=1 → 17 after 13 edges, 0 after 81 edges. It holds 0 with `changed`=0.
4. Idle drift: INIT_TEMP=20, AMBIENT=15, inputs idle → `temperature` reaches 15 at the 40th edge (steps every 8 edges) and holds there. Repeat with INIT_TEMP=10 → rises to 15.
5. Conflict: both inputs high for 1 cycle at `temperature`=22 → `fault`=1 on that edge. `temperature` stays 22 through 100 further cycles of `heating`=1, until `rst` clears everything to 20/0/0.
6. Mode chatter: alternate `heating`/`cooling` every 3 cycles (RATE_DIV=4) for 60 cycles → `temperature` constant at 20, `changed` never asserted, `fault`=0.
